// File: rtl/psum_accum_ctrl_pkg.sv
// Shared constants, mode encodings and FSM state type for the PSUM
// accumulation sequencer.
package psum_accum_ctrl_pkg;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int ADDR_BW = 4;
    localparam int VEC_BW  = COL * PSUM_BW;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_ACC  = 2'b01;
    localparam logic [1:0] MODE_RELU = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PASS,
        ST_READ,
        ST_WRITE,
        ST_FIN
    } state_t;

endpackage

// File: rtl/psum_accum_ctrl_if.sv
// Run control, OFIFO head/pop and PSUM SRAM port bundled into one interface.
// The master side is the sequencer, the slave side is the surrounding fabric.
interface psum_accum_ctrl_if;
    import psum_accum_ctrl_pkg::*;

    logic                 start;
    logic [1:0]           mode;
    logic [ADDR_BW-1:0]   base_addr;
    logic [ADDR_BW:0]     len;
    logic                 busy;
    logic                 done;

    logic                 ofifo_valid;
    logic [VEC_BW-1:0]    ofifo_out;
    logic                 ofifo_rd;

    logic                 psum_cen;
    logic                 psum_wen;
    logic [ADDR_BW-1:0]   psum_a;
    logic [VEC_BW-1:0]    psum_d;
    logic [VEC_BW-1:0]    psum_q;

    modport master (
        input  start, mode, base_addr, len,
        output busy, done,
        input  ofifo_valid, ofifo_out,
        output ofifo_rd,
        output psum_cen, psum_wen, psum_a, psum_d,
        input  psum_q
    );

    modport slave (
        output start, mode, base_addr, len,
        input  busy, done,
        output ofifo_valid, ofifo_out,
        input  ofifo_rd,
        input  psum_cen, psum_wen, psum_a, psum_d,
        output psum_q
    );

endinterface

// File: rtl/sfp.sv
// Single-lane special-function processor: passthrough, wrapping accumulate,
// or activation applied to the stored partial sum.
module sfp #(
    parameter int PSUM_BW = 16
) (
    input  logic [PSUM_BW-1:0] psum_in,
    input  logic [PSUM_BW-1:0] ofifo_in,
    input  logic               passthrough,
    input  logic               accum,
    input  logic [1:0]         act_func,
    output logic [PSUM_BW-1:0] sfp_out
);

    always_comb begin
        sfp_out = psum_in;
        if (passthrough) begin
            sfp_out = ofifo_in;
        end else if (accum) begin
            sfp_out = psum_in + ofifo_in;
        end else if (act_func == 2'b10 && psum_in[PSUM_BW-1]) begin
            // ReLU: negative sums clamp to zero, positive pass unchanged
            sfp_out = '0;
        end
    end

endmodule

// File: rtl/psum_accum_ctrl.sv
// Sequencer that streams OFIFO vectors through the SFP lanes into the PSUM
// SRAM in passthrough, read-modify-write accumulate, or in-place ReLU mode.
module psum_accum_ctrl
    import psum_accum_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    psum_accum_ctrl_if.master bus
);

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [ADDR_BW-1:0] base_q, base_d;
    logic [ADDR_BW:0]   len_q, len_d;
    logic [ADDR_BW:0]   idx_q, idx_d;

    logic [ADDR_BW:0]   idx_inc;
    logic               idx_last;
    logic               cen, wen, rd, done;
    logic               passthrough, accum;
    logic [1:0]         act_func;
    logic [VEC_BW-1:0]  lane_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_PASS;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    assign idx_inc  = idx_q + 1'b1;
    assign idx_last = (idx_inc == len_q);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cen     = 1'b1;
        wen     = 1'b1;
        rd      = 1'b0;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mode_d = bus.mode;
                    base_d = bus.base_addr;
                    len_d  = bus.len;
                    idx_d  = '0;
                    if (bus.len == '0)
                        state_d = ST_FIN;
                    else if (bus.mode == MODE_PASS)
                        state_d = ST_PASS;
                    else
                        state_d = ST_READ;
                end
            end
            ST_PASS: begin
                if (bus.ofifo_valid) begin
                    cen   = 1'b0;
                    wen   = 1'b0;
                    rd    = 1'b1;
                    idx_d = idx_inc;
                    if (idx_last)
                        state_d = ST_FIN;
                end
            end
            ST_READ: begin
                // Accumulate waits for the FIFO head before touching the SRAM,
                // so the WRITE that follows always has an operand to add.
                if (!(mode_q == MODE_ACC && !bus.ofifo_valid)) begin
                    cen     = 1'b0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                cen     = 1'b0;
                wen     = 1'b0;
                rd      = (mode_q == MODE_ACC);
                idx_d   = idx_inc;
                state_d = idx_last ? ST_FIN : ST_READ;
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign passthrough = (mode_q == MODE_PASS);
    assign accum       = (mode_q == MODE_ACC);
    assign act_func    = {mode_q[1], 1'b0};

    generate
        for (genvar gi = 0; gi < COL; gi++) begin : g_lane
            sfp #(
                .PSUM_BW (PSUM_BW)
            ) u_sfp (
                .psum_in     (bus.psum_q[gi*PSUM_BW +: PSUM_BW]),
                .ofifo_in    (bus.ofifo_out[gi*PSUM_BW +: PSUM_BW]),
                .passthrough (passthrough),
                .accum       (accum),
                .act_func    (act_func),
                .sfp_out     (lane_out[gi*PSUM_BW +: PSUM_BW])
            );
        end
    endgenerate

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done;
    assign bus.ofifo_rd = rd;
    assign bus.psum_cen = cen;
    assign bus.psum_wen = wen;
    assign bus.psum_a   = base_q + idx_q[ADDR_BW-1:0];
    assign bus.psum_d   = lane_out;

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Directed bench for psum_accum_ctrl with behavioural SRAM and show-ahead FIFO.
module tb_psum_accum_ctrl;
    import psum_accum_ctrl_pkg::*;

    logic clk;
    logic reset;

    psum_accum_ctrl_if bus ();

    psum_accum_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural environment: SRAM with 1-cycle read, FIFO with show-ahead head
    logic [VEC_BW-1:0]  mem [16];
    logic [VEC_BW-1:0]  q_reg;
    logic               pre_we;
    logic [ADDR_BW-1:0] pre_a;
    logic [VEC_BW-1:0]  pre_d;
    logic [VEC_BW-1:0]  fifo_mem [16];
    int                 wp = 0;
    int                 rp = 0;
    logic               hold;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_a] <= pre_d;
        else if (!bus.psum_cen) begin
            if (!bus.psum_wen) mem[bus.psum_a] <= bus.psum_d;
            else               q_reg <= mem[bus.psum_a];
        end
        if (bus.ofifo_rd) rp <= rp + 1;
    end

    assign bus.psum_q      = q_reg;
    assign bus.ofifo_valid = (wp != rp) && !hold;
    assign bus.ofifo_out   = fifo_mem[rp[3:0]];

    function automatic logic [VEC_BW-1:0] rep(input logic [PSUM_BW-1:0] v);
        logic [VEC_BW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*PSUM_BW +: PSUM_BW] = v;
        return r;
    endfunction

    function automatic logic [VEC_BW-1:0] ramp(input logic [PSUM_BW-1:0] v);
        logic [VEC_BW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*PSUM_BW +: PSUM_BW] = v + PSUM_BW'(i * 16'h0100);
        return r;
    endfunction

    task automatic check(input string tag, input logic [VEC_BW-1:0] got, input logic [VEC_BW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic push(input logic [VEC_BW-1:0] v);
        fifo_mem[wp[3:0]] = v;
        wp++;
    endtask

    task automatic preload(input logic [ADDR_BW-1:0] a, input logic [VEC_BW-1:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] m, input logic [ADDR_BW-1:0] b, input logic [ADDR_BW:0] l,
                          input int stall, output int done_cyc, output int pops,
                          output logic [63:0] cen_mask, output logic [63:0] wen_mask);
        done_cyc = -1; pops = 0; cen_mask = '0; wen_mask = '0;
        @(negedge clk);
        bus.mode = m; bus.base_addr = b; bus.len = l; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int cyc = 1; cyc < 40; cyc++) begin
            hold = (cyc <= stall);
            @(negedge clk);
            if (!bus.psum_cen) cen_mask[cyc] = 1'b1;
            if (!bus.psum_wen) wen_mask[cyc] = 1'b1;
            if (bus.ofifo_rd)  pops++;
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        hold = 1'b0;
    endtask

    int          dc, np;
    logic [63:0] cm, wm;
    logic        saw_busy, saw_cen, saw_done;

    initial begin
        reset = 1'b1; bus.start = 1'b0; bus.mode = 2'b00; bus.base_addr = '0; bus.len = '0;
        pre_we = 1'b0; pre_a = '0; pre_d = '0; hold = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", VEC_BW'(bus.busy), 0);
        check("rst_done", VEC_BW'(bus.done), 0);
        check("rst_rd",   VEC_BW'(bus.ofifo_rd), 0);
        check("rst_cen",  VEC_BW'(bus.psum_cen), 1);
        check("rst_wen",  VEC_BW'(bus.psum_wen), 1);
        check("rst_a",    VEC_BW'(bus.psum_a), 0);

        // Passthrough base 3, four vectors
        push(ramp(16'd5)); push(ramp(16'd6)); push(ramp(16'd7)); push(ramp(16'd8));
        run_op(MODE_PASS, 4'd3, 5'd4, 0, dc, np, cm, wm);
        check("pass_done", dc, 5);
        check("pass_pops", np, 4);
        check("pass_cen",  cm, 64'h1E);
        check("pass_m3",   mem[3], ramp(16'd5));
        check("pass_m4",   mem[4], ramp(16'd6));
        check("pass_m5",   mem[5], ramp(16'd7));
        check("pass_m6",   mem[6], ramp(16'd8));

        // Accumulate 100 + (-30) = 70
        preload(4'd0, rep(16'd100));
        push(rep(16'hFFE2));
        run_op(MODE_ACC, 4'd0, 5'd1, 0, dc, np, cm, wm);
        check("acc_done", dc, 3);
        check("acc_pops", np, 1);
        check("acc_cen",  cm, 64'h06);
        check("acc_wen",  wm, 64'h04);
        check("acc_m0",   mem[0], rep(16'd70));

        // Wrapping add and address wrap 15 -> 0
        preload(4'd15, rep(16'h7FFF));
        preload(4'd0,  rep(16'h0010));
        push(rep(16'h0001)); push(rep(16'h0002));
        run_op(MODE_ACC, 4'd15, 5'd2, 0, dc, np, cm, wm);
        check("wrap_done", dc, 5);
        check("wrap_pops", np, 2);
        check("wrap_cen",  cm, 64'h1E);
        check("wrap_m15",  mem[15], rep(16'h8000));
        check("wrap_m0",   mem[0], rep(16'h0012));

        // ReLU with a vector waiting in the FIFO that must not be popped
        preload(4'd8, rep(16'h8001));
        preload(4'd9, rep(16'h0042));
        push(rep(16'h0005));
        run_op(MODE_RELU, 4'd8, 5'd2, 0, dc, np, cm, wm);
        check("relu_done",  dc, 5);
        check("relu_pops",  np, 0);
        check("relu_wen",   wm, 64'h14);
        check("relu_m8",    mem[8], rep(16'h0000));
        check("relu_m9",    mem[9], rep(16'h0042));
        check("relu_level", wp - rp, 1);

        // Accumulate with the FIFO held empty for three cycles
        preload(4'd2, rep(16'h0100));
        run_op(MODE_ACC, 4'd2, 5'd1, 3, dc, np, cm, wm);
        check("stall_done", dc, 6);
        check("stall_pops", np, 1);
        check("stall_cen",  cm, 64'h30);
        check("stall_m2",   mem[2], rep(16'h0105));

        // Empty run
        run_op(MODE_ACC, 4'd5, 5'd0, 0, dc, np, cm, wm);
        check("len0_done", dc, 1);
        check("len0_cen",  cm, 64'h0);

        // Reset while in WRITE
        preload(4'd4, rep(16'h0010));
        push(rep(16'h0001));
        @(negedge clk);
        bus.mode = MODE_ACC; bus.base_addr = 4'd4; bus.len = 5'd1; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("rstw_in_write", VEC_BW'(bus.psum_wen), 0);
        @(posedge clk); #1 reset = 1'b0;
        saw_busy = 1'b0; saw_cen = 1'b0; saw_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.busy)      saw_busy = 1'b1;
            if (!bus.psum_cen) saw_cen  = 1'b1;
            if (bus.done)      saw_done = 1'b1;
        end
        check("rstw_busy", VEC_BW'(saw_busy), 0);
        check("rstw_cen",  VEC_BW'(saw_cen), 0);
        check("rstw_done", VEC_BW'(saw_done), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
